// File: rtl/mult_share_sched_pkg.sv
// Shared constants, pipeline-stage record and helpers for the shared multiplier scheduler.
package mult_pkg;

  localparam int MULT_OP_W     = 32;
  localparam int MULT_PROD_W   = 64;
  localparam int MULT_ID_MAX_W = 4;

  typedef struct packed {
    logic                     valid;
    logic [MULT_ID_MAX_W-1:0] id;
    logic [MULT_PROD_W-1:0]   product;
  } mult_stage_t;

  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/mult_share_sched_if.sv
// Requester/consumer bundle of the shared multiplier: packed operands in, tagged product out.
interface mult_share_sched_if
  import mult_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*MULT_OP_W-1:0] req_a;
  logic [NUM_REQ*MULT_OP_W-1:0] req_b;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [MULT_PROD_W-1:0]       rsp_data;
  logic [ID_W-1:0]              rsp_id;
  logic                         busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, busy
  );

endinterface

// File: rtl/mult_share_sched_rr_arbiter.sv
// Round-robin arbiter: grants the lowest requester at or above the pointer, else wraps.
module rr_arbiter
  import mult_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (clog2_f(NUM_REQ) < 1) ? 1 : clog2_f(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_adv_en,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [PTR_W-1:0]   o_grant_idx
);

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic             w_found;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && i_req[i] && (PTR_W'(i) >= r_ptr)) begin
        w_found     = 1'b1;
        o_grant[i]  = 1'b1;
        o_grant_idx = PTR_W'(i);
      end
    end
    // Nothing at or above the pointer: wrap to the lowest requester below it.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && i_req[i]) begin
        w_found     = 1'b1;
        o_grant[i]  = 1'b1;
        o_grant_idx = PTR_W'(i);
      end
    end
  end

  assign w_ptr_nxt = (o_grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : o_grant_idx + PTR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_adv_en && w_found) begin
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule

// File: rtl/mult_share_sched.sv
// One pipelined 32x32 unsigned multiplier shared round-robin among NUM_REQ requesters.
// Optional per-requester issue and stall statistics under MULT_SHARE_SCHED_STATS_EN.
module mult_share_sched
  import mult_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LAT     = 3,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mult_share_sched_if.slave      bus
`ifdef MULT_SHARE_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]  stat_issue_cnt,
  output logic [15:0]            stat_stall_cnt
`endif
);

  if (ID_W != clog2_f(NUM_REQ)) begin : g_bad_id_w
    $error("ID_W must equal clog2(NUM_REQ)");
  end
  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("NUM_REQ must be in 2..16");
  end
  if (LAT < 1 || LAT > 8) begin : g_bad_lat
    $error("LAT must be in 1..8");
  end

  logic [NUM_REQ-1:0]     w_grant;
  logic [ID_W-1:0]        w_gidx;
  logic                   w_adv;
  logic                   w_xfer;
  logic [MULT_OP_W-1:0]   w_a;
  logic [MULT_OP_W-1:0]   w_b;
  logic [MULT_PROD_W-1:0] w_prod_p1;
  mult_stage_t            w_stg_in;
  mult_stage_t            w_last;
  logic                   w_busy_tail;
  logic                   w_unused_id;

  logic                   r_vld_p0;
  logic [ID_W-1:0]        r_id_p0;
  logic [MULT_OP_W-1:0]   r_a_p0;
  logic [MULT_OP_W-1:0]   r_b_p0;

  // The whole pipeline freezes while a result sits unaccepted at the output.
  assign w_adv  = !(w_last.valid && !bus.rsp_ready);
  assign w_xfer = w_adv && (|w_grant);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (ID_W)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       (bus.req_valid),
    .i_adv_en    (w_adv),
    .o_grant     (w_grant),
    .o_grant_idx (w_gidx)
  );

  assign bus.req_ready = w_grant & {NUM_REQ{w_adv && rst_n}};

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_a = bus.req_a[i*MULT_OP_W +: MULT_OP_W];
        w_b = bus.req_b[i*MULT_OP_W +: MULT_OP_W];
      end
    end
  end

  // Stage 0: operand capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p0 <= 1'b0;
      r_id_p0  <= '0;
      r_a_p0   <= '0;
      r_b_p0   <= '0;
    end else if (w_adv) begin
      r_vld_p0 <= w_xfer;
      if (w_xfer) begin
        r_id_p0 <= w_gidx;
        r_a_p0  <= w_a;
        r_b_p0  <= w_b;
      end
    end
  end

  // Stage 0 -> 1: full-width unsigned product
  assign w_prod_p1 = MULT_PROD_W'(r_a_p0) * MULT_PROD_W'(r_b_p0);
  assign w_stg_in  = '{valid: r_vld_p0, id: MULT_ID_MAX_W'(r_id_p0), product: w_prod_p1};

  if (LAT > 1) begin : g_tail
    mult_stage_t r_stg_p [LAT-1];

    // Stages 1..LAT-1: product carry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < LAT - 1; k++) r_stg_p[k] <= '0;
      end else if (w_adv) begin
        r_stg_p[0] <= w_stg_in;
        for (int k = 1; k < LAT - 1; k++) r_stg_p[k] <= r_stg_p[k-1];
      end
    end

    always_comb begin
      w_busy_tail = 1'b0;
      for (int k = 0; k < LAT - 1; k++) w_busy_tail = w_busy_tail | r_stg_p[k].valid;
    end

    assign w_last = r_stg_p[LAT-2];
  end else begin : g_no_tail
    assign w_busy_tail = 1'b0;
    assign w_last      = w_stg_in;
  end

  assign bus.rsp_valid = w_last.valid;
  assign bus.rsp_data  = w_last.product;
  assign bus.rsp_id    = w_last.id[ID_W-1:0];
  assign bus.busy      = r_vld_p0 | w_busy_tail;
  assign w_unused_id   = ^w_last.id;

`ifdef MULT_SHARE_SCHED_STATS_EN
  logic [NUM_REQ-1:0][15:0] r_issue_cnt;
  logic [15:0]              r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_xfer && w_grant[i] && (r_issue_cnt[i] != 16'hFFFF)) begin
          r_issue_cnt[i] <= r_issue_cnt[i] + 16'd1;
        end
      end
      if (!w_adv && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign stat_issue_cnt = r_issue_cnt;
  assign stat_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_mult_share_sched.sv
// Directed, table-driven bench for mult_share_sched (NUM_REQ=4, LAT=3).
module tb_mult_share_sched;
  import mult_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int LAT     = 3;
  localparam int ID_W    = 2;

  typedef struct {
    int          req;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp_data;
    logic [1:0]  exp_id;
  } vec_t;

  typedef struct {
    logic [3:0]  vld;
    logic        rdy;
    logic [3:0]  exp_ready;
    logic        exp_rv;
    logic [63:0] exp_data;
    logic [1:0]  exp_id;
  } cyc_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  vec_t vecs [5];
  cyc_t seq [$];

  mult_share_sched_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

`ifdef MULT_SHARE_SCHED_STATS_EN
  logic [NUM_REQ*16-1:0] stat_issue_cnt;
  logic [15:0]           stat_stall_cnt;
`endif

  mult_share_sched #(
    .NUM_REQ (NUM_REQ),
    .LAT     (LAT),
    .ID_W    (ID_W)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus)
`ifdef MULT_SHARE_SCHED_STATS_EN
    ,
    .stat_issue_cnt (stat_issue_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_ops_linear();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_a[i*32 +: 32] = 32'(i + 1);
      bus.req_b[i*32 +: 32] = 32'd10;
    end
  endtask

  task automatic push(input logic [3:0] vld, input logic rdy, input logic [3:0] er,
                      input logic rv, input logic [63:0] d, input logic [1:0] id);
    cyc_t c;
    c.vld = vld; c.rdy = rdy; c.exp_ready = er; c.exp_rv = rv; c.exp_data = d; c.exp_id = id;
    seq.push_back(c);
  endtask

  // Entered and left 1 time unit after a rising edge.
  task automatic run_seq(input string tag);
    foreach (seq[c]) begin
      bus.req_valid = seq[c].vld;
      bus.rsp_ready = seq[c].rdy;
      #1;
      chk($sformatf("%s_c%0d_ready", tag, c), 64'(bus.req_ready), 64'(seq[c].exp_ready));
      chk($sformatf("%s_c%0d_rvalid", tag, c), 64'(bus.rsp_valid), 64'(seq[c].exp_rv));
      if (seq[c].exp_rv) begin
        chk($sformatf("%s_c%0d_data", tag, c), bus.rsp_data, seq[c].exp_data);
        chk($sformatf("%s_c%0d_id", tag, c), 64'(bus.rsp_id), 64'(seq[c].exp_id));
      end
      @(posedge clk); #1;
    end
    seq.delete();
  endtask

  task automatic run_vec(input int n, input vec_t v);
    logic [3:0] oh;
    oh = 4'b0001 << v.req;
    bus.rsp_ready = 1'b1;
    bus.req_valid = oh;
    bus.req_a[v.req*32 +: 32] = v.a;
    bus.req_b[v.req*32 +: 32] = v.b;
    #1;
    chk($sformatf("vec%0d_ready", n), 64'(bus.req_ready), 64'(oh));
    @(posedge clk); #1;
    bus.req_valid = '0;
    for (int k = 0; k < LAT - 1; k++) begin
      chk($sformatf("vec%0d_early_rvalid", n), 64'(bus.rsp_valid), 64'd0);
      @(posedge clk); #1;
    end
    chk($sformatf("vec%0d_rvalid", n), 64'(bus.rsp_valid), 64'd1);
    chk($sformatf("vec%0d_data", n), bus.rsp_data, v.exp_data);
    chk($sformatf("vec%0d_id", n), 64'(bus.rsp_id), 64'(v.exp_id));
    @(posedge clk); #1;
    chk($sformatf("vec%0d_rvalid_after", n), 64'(bus.rsp_valid), 64'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    vecs[0] = '{req: 0, a: 32'd1000,       b: 32'd1000,       exp_data: 64'd1000000,             exp_id: 2'd0};
    vecs[1] = '{req: 2, a: 32'd7,          b: 32'd6,          exp_data: 64'd42,                  exp_id: 2'd2};
    vecs[2] = '{req: 0, a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  exp_data: 64'hFFFF_FFFE_0000_0001, exp_id: 2'd0};
    vecs[3] = '{req: 1, a: 32'd0,          b: 32'h1234_5678,  exp_data: 64'd0,                   exp_id: 2'd1};
    vecs[4] = '{req: 3, a: 32'h0001_0000,  b: 32'h0001_0000,  exp_data: 64'h0000_0001_0000_0000, exp_id: 2'd3};

    rst_n         = 1'b0;
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b1;
    set_ops_linear();
    #3;
    chk("reset_rvalid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_data",   bus.rsp_data,        64'd0);
    chk("reset_id",     64'(bus.rsp_id),     64'd0);
    chk("reset_busy",   64'(bus.busy),       64'd0);
    chk("reset_ready",  64'(bus.req_ready),  64'd0);
    bus.req_valid = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // All requesters valid from pointer 0.
    set_ops_linear();
    push(4'hF, 1, 4'b0001, 0, 64'd0,  2'd0);
    push(4'hF, 1, 4'b0010, 0, 64'd0,  2'd0);
    push(4'hF, 1, 4'b0100, 0, 64'd0,  2'd0);
    push(4'hF, 1, 4'b1000, 1, 64'd10, 2'd0);
    push(4'hF, 1, 4'b0001, 1, 64'd20, 2'd1);
    push(4'h0, 1, 4'b0000, 1, 64'd30, 2'd2);
    push(4'h0, 1, 4'b0000, 1, 64'd40, 2'd3);
    push(4'h0, 1, 4'b0000, 1, 64'd10, 2'd0);
    push(4'h0, 1, 4'b0000, 0, 64'd0,  2'd0);
    run_seq("rr");

    // Five issues from pointer 1 with a four-cycle consumer stall.
    push(4'hF, 1, 4'b0010, 0, 64'd0,  2'd0);
    push(4'hF, 1, 4'b0100, 0, 64'd0,  2'd0);
    push(4'hF, 1, 4'b1000, 0, 64'd0,  2'd0);
    push(4'hF, 0, 4'b0000, 1, 64'd20, 2'd1);
    push(4'hF, 0, 4'b0000, 1, 64'd20, 2'd1);
    push(4'hF, 0, 4'b0000, 1, 64'd20, 2'd1);
    push(4'hF, 0, 4'b0000, 1, 64'd20, 2'd1);
    push(4'hF, 1, 4'b0001, 1, 64'd20, 2'd1);
    push(4'hF, 1, 4'b0010, 1, 64'd30, 2'd2);
    push(4'h0, 1, 4'b0000, 1, 64'd40, 2'd3);
    push(4'h0, 1, 4'b0000, 1, 64'd10, 2'd0);
    push(4'h0, 1, 4'b0000, 1, 64'd20, 2'd1);
    push(4'h0, 1, 4'b0000, 0, 64'd0,  2'd0);
    run_seq("bp");

    // Three products in flight (grants 2,3,0; pointer then at 1), then reset.
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
    end
    chk("inflight_busy",   64'(bus.busy),      64'd1);
    chk("inflight_rvalid", 64'(bus.rsp_valid), 64'd1);
    chk("inflight_data",   bus.rsp_data,       64'd30);
    rst_n = 1'b0;
    #1;
    chk("midrst_rvalid", 64'(bus.rsp_valid), 64'd0);
    chk("midrst_data",   bus.rsp_data,       64'd0);
    chk("midrst_id",     64'(bus.rsp_id),    64'd0);
    chk("midrst_busy",   64'(bus.busy),      64'd0);
    chk("midrst_ready",  64'(bus.req_ready), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    bus.req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("postrst_rvalid%0d", k), 64'(bus.rsp_valid), 64'd0);
      chk($sformatf("postrst_busy%0d", k),   64'(bus.busy),      64'd0);
    end
    push(4'b0101, 1, 4'b0001, 0, 64'd0,  2'd0);
    push(4'b0000, 1, 4'b0000, 0, 64'd0,  2'd0);
    push(4'b0000, 1, 4'b0000, 0, 64'd0,  2'd0);
    push(4'b0000, 1, 4'b0000, 1, 64'd10, 2'd0);
    push(4'b0000, 1, 4'b0000, 0, 64'd0,  2'd0);
    run_seq("rstptr");

`ifdef MULT_SHARE_SCHED_STATS_EN
    rst_n = 1'b0;
    #1;
    chk("stat_rst_issue", 64'(stat_issue_cnt), 64'd0);
    chk("stat_rst_stall", 64'(stat_stall_cnt), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    push(4'b0010, 1, 4'b0010, 0, 64'd0,  2'd0);
    push(4'b0010, 1, 4'b0010, 0, 64'd0,  2'd0);
    push(4'b0010, 1, 4'b0010, 0, 64'd0,  2'd0);
    push(4'b0000, 0, 4'b0000, 1, 64'd20, 2'd1);
    push(4'b0000, 0, 4'b0000, 1, 64'd20, 2'd1);
    push(4'b0000, 1, 4'b0000, 1, 64'd20, 2'd1);
    push(4'b0000, 1, 4'b0000, 1, 64'd20, 2'd1);
    push(4'b0000, 1, 4'b0000, 1, 64'd20, 2'd1);
    push(4'b0000, 1, 4'b0000, 0, 64'd0,  2'd0);
    run_seq("stat");
    chk("stat_issue", 64'(stat_issue_cnt), {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd3, 16'd0});
    chk("stat_stall", 64'(stat_stall_cnt), 64'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
